clock_set_controller: RTL and testbench

//  Sequences and configures the DigiLock time-of-day counter from the system clock.
//  - Generates the 1 Hz advance enable for the counter.
//  - Provides a user SET mode (mode/inc/dec buttons) that edits hours, minutes, seconds.
//  - Commits the edited time to the counter as a one-cycle load.
//  - Sits between the debounced keypad buttons and the time counter; feeds the display path.

---
 rtl/clock_set_controller_pkg.sv | 29 ++
 rtl/clock_set_controller_if.sv | 26 ++
 rtl/clock_set_controller_field_wrap_adj.sv | 16 +
 rtl/clock_set_controller.sv | 152 +++++++++++++++
 tb/tb_clock_set_controller.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/clock_set_controller_pkg.sv
// Shared widths, limits, state/field encodings and the capture sanitiser for the
// DigiLock clock-set controller.
package clock_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int TIME_W   = 17;
  localparam int MAX_HOUR = 23;
  localparam int MAX_MS   = 59;

  typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, COMMIT} state_t;
  typedef enum logic [1:0] {FIELD_NONE, FIELD_HOUR, FIELD_MIN, FIELD_SEC} field_t;

  // Any field outside its legal range is captured as zero.
  function automatic logic [TIME_W-1:0] sanitize_time(input logic [TIME_W-1:0] t);
    logic [HOUR_W-1:0] h;
    logic [MIN_W-1:0]  m;
    logic [SEC_W-1:0]  s;
    h = t[TIME_W-1 -: HOUR_W];
    m = t[SEC_W +: MIN_W];
    s = t[SEC_W-1:0];
    if (h > HOUR_W'(MAX_HOUR)) h = '0;
    if (m > MIN_W'(MAX_MS))    m = '0;
    if (s > SEC_W'(MAX_MS))    s = '0;
    return {h, m, s};
  endfunction

endpackage

// File: rtl/clock_set_controller_if.sv
// Keypad/time-counter side of the clock-set controller: the master drives buttons
// and current time, the slave (the controller) drives tick, load and display info.
interface clock_set_controller_if;
  import clock_pkg::*;

  logic              btn_mode;
  logic              btn_inc;
  logic              btn_dec;
  logic [TIME_W-1:0] cur_time;
  logic              tick_1hz;
  logic              load;
  logic [TIME_W-1:0] load_time;
  logic              set_active;
  logic [1:0]        field_sel;
  logic              blink;

  modport master (
    output btn_mode, btn_inc, btn_dec, cur_time,
    input  tick_1hz, load, load_time, set_active, field_sel, blink
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec, cur_time,
    output tick_1hz, load, load_time, set_active, field_sel, blink
  );
endinterface

// File: rtl/clock_set_controller_field_wrap_adj.sv
// One time field stepped up or down with wraparound between 0 and max.
module field_wrap_adj #(
  parameter int W = 6
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] max,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] next
);
  always_comb begin
    next = value;
    if (inc && !dec)      next = (value == max)     ? '0  : value + W'(1);
    else if (dec && !inc) next = (value == '0)      ? max : value - W'(1);
  end
endmodule

// File: rtl/clock_set_controller.sv
// DigiLock clock-set controller: 1 Hz prescaler, SET-mode editor FSM, blink divider.
// Optional idle abort of SET mode when CLOCK_SET_TIMEOUT_EN is defined.
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TIMEOUT_S = 30
) (
  input logic                  clk,
  input logic                  rst_n,
  clock_set_controller_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(CLK_HZ + 1);
  localparam int unsigned BLK_N = (CLK_HZ / 4 > 1) ? CLK_HZ / 4 : 1;
  localparam int unsigned BLK_W = $clog2(BLK_N + 1);

  state_t             state, state_nxt;
  field_t             field;
  logic [CNT_W-1:0]   pre_cnt;
  logic [BLK_W-1:0]   blk_cnt;
  logic               blink_q;
  logic [TIME_W-1:0]  edit;
  logic               in_set, pre_wrap, any_btn, timeout, edit_ok;
  logic               tick, load, set_active;
  logic [HOUR_W-1:0]  h_nxt;
  logic [MIN_W-1:0]   m_nxt;
  logic [SEC_W-1:0]   s_nxt;

  assign in_set   = (state == SET_H) || (state == SET_M) || (state == SET_S);
  assign pre_wrap = (pre_cnt == CNT_W'(CLK_HZ - 1));
  assign any_btn  = bus.btn_mode || bus.btn_inc || bus.btn_dec;
  // A mode press in the same cycle swallows inc/dec.
  assign edit_ok  = !bus.btn_mode;

`ifdef CLOCK_SET_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_S + 1);
  logic [CNT_W-1:0]  idle_pre;
  logic [IDLE_W-1:0] idle_sec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_pre <= '0;
      idle_sec <= '0;
    end else if (!in_set || any_btn) begin
      idle_pre <= '0;
      idle_sec <= '0;
    end else if (idle_pre == CNT_W'(CLK_HZ - 1)) begin
      idle_pre <= '0;
      idle_sec <= idle_sec + IDLE_W'(1);
    end else begin
      idle_pre <= idle_pre + CNT_W'(1);
    end
  end

  assign timeout = in_set && !any_btn && (idle_pre == CNT_W'(CLK_HZ - 1)) &&
                   (idle_sec == IDLE_W'(TIMEOUT_S - 1));
`else
  assign timeout = 1'b0;
`endif

  field_wrap_adj #(.W(HOUR_W)) u_hour (
    .value(edit[TIME_W-1 -: HOUR_W]), .max(HOUR_W'(MAX_HOUR)),
    .inc(bus.btn_inc && edit_ok && state == SET_H),
    .dec(bus.btn_dec && edit_ok && state == SET_H), .next(h_nxt));
  field_wrap_adj #(.W(MIN_W)) u_min (
    .value(edit[SEC_W +: MIN_W]), .max(MIN_W'(MAX_MS)),
    .inc(bus.btn_inc && edit_ok && state == SET_M),
    .dec(bus.btn_dec && edit_ok && state == SET_M), .next(m_nxt));
  field_wrap_adj #(.W(SEC_W)) u_sec (
    .value(edit[SEC_W-1:0]), .max(SEC_W'(MAX_MS)),
    .inc(bus.btn_inc && edit_ok && state == SET_S),
    .dec(bus.btn_dec && edit_ok && state == SET_S), .next(s_nxt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tick       = 1'b0;
    load       = 1'b0;
    set_active = 1'b0;
    field      = FIELD_NONE;
    case (state)
      RUN: begin
        tick = pre_wrap;
        if (bus.btn_mode) state_nxt = SET_H;
      end
      SET_H: begin
        set_active = 1'b1;
        field      = FIELD_HOUR;
        if (bus.btn_mode)  state_nxt = SET_M;
        else if (timeout)  state_nxt = RUN;
      end
      SET_M: begin
        set_active = 1'b1;
        field      = FIELD_MIN;
        if (bus.btn_mode)  state_nxt = SET_S;
        else if (timeout)  state_nxt = RUN;
      end
      SET_S: begin
        set_active = 1'b1;
        field      = FIELD_SEC;
        if (bus.btn_mode)  state_nxt = COMMIT;
        else if (timeout)  state_nxt = RUN;
      end
      COMMIT: begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Prescaler only runs in RUN, so it restarts from 0 after any SET/COMMIT visit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pre_cnt <= '0;
    else if (state != RUN)   pre_cnt <= '0;
    else if (pre_wrap)       pre_cnt <= '0;
    else                     pre_cnt <= pre_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
      blink_q <= 1'b0;
    end else if (!in_set) begin
      blk_cnt <= '0;
      blink_q <= 1'b0;
    end else if (blk_cnt == BLK_W'(BLK_N - 1)) begin
      blk_cnt <= '0;
      blink_q <= ~blink_q;
    end else begin
      blk_cnt <= blk_cnt + BLK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          edit <= '0;
    else if (state == RUN && bus.btn_mode) edit <= sanitize_time(bus.cur_time);
    else if (in_set)                     edit <= {h_nxt, m_nxt, s_nxt};
  end

  assign bus.tick_1hz   = tick;
  assign bus.load       = load;
  assign bus.load_time  = edit;
  assign bus.set_active = set_active;
  assign bus.field_sel  = field;
  assign bus.blink      = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with CLK_HZ=8, TIMEOUT_S=2; timeout
// expectations follow CLOCK_SET_TIMEOUT_EN.
module tb_clock_set_controller;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  clock_set_controller_if bus ();

  clock_set_controller #(.CLK_HZ(8), .TIMEOUT_S(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    hh = 5'(h);
    mm = 6'(m);
    ss = 6'(s);
    return {hh, mm, ss};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic i, input logic d);
    bus.btn_mode = m;
    bus.btn_inc  = i;
    bus.btn_dec  = d;
    @(posedge clk);
    #1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_dec  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tick"},  32'(bus.tick_1hz),   32'd0);
    check({tag, "_load"},  32'(bus.load),       32'd0);
    check({tag, "_set"},   32'(bus.set_active), 32'd0);
    check({tag, "_field"}, 32'(bus.field_sel),  32'd0);
    check({tag, "_blink"}, 32'(bus.blink),      32'd0);
    check({tag, "_ltime"}, 32'(bus.load_time),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_dec  = 1'b0;
    bus.cur_time = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // 1: free-running prescaler after reset release
    for (int c = 0; c < 40; c++) begin
      check("run_tick",  32'(bus.tick_1hz),   32'((c % 8) == 7));
      check("run_load",  32'(bus.load),       32'd0);
      check("run_set",   32'(bus.set_active), 32'd0);
      check("run_blink", 32'(bus.blink),      32'd0);
      step();
    end

    // 2: full edit 12:34:56 -> 14:33:56 and commit
    bus.cur_time = hms(12, 34, 56);
    pulse(1, 0, 0);
    check("enter_set",   32'(bus.set_active), 32'd1);
    check("enter_field", 32'(bus.field_sel),  32'd1);
    check("enter_edit",  32'(bus.load_time),  32'(hms(12, 34, 56)));
    check("set_tick",    32'(bus.tick_1hz),   32'd0);
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    check("hour_inc2",   32'(bus.load_time),  32'(hms(14, 34, 56)));
    pulse(1, 0, 0);
    check("field_min",   32'(bus.field_sel),  32'd2);
    pulse(0, 0, 1);
    check("min_dec",     32'(bus.load_time),  32'(hms(14, 33, 56)));
    pulse(1, 0, 0);
    check("field_sec",   32'(bus.field_sel),  32'd3);
    pulse(1, 0, 0);
    check("commit_load", 32'(bus.load),       32'd1);
    check("commit_time", 32'(bus.load_time),  32'h0E878);
    check("commit_set",  32'(bus.set_active), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("post_load",  32'(bus.load),     32'd0);
      check("post_tick",  32'(bus.tick_1hz), 32'(k == 8));
    end

    // 3: wraparound and simultaneous inc+dec
    bus.cur_time = hms(23, 0, 0);
    pulse(1, 0, 0);
    check("wrap_entry",  32'(bus.load_time),  32'(hms(23, 0, 0)));
    pulse(0, 1, 0);
    check("hour_wrap",   32'(bus.load_time),  32'(hms(0, 0, 0)));
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    check("min_wrap",    32'(bus.load_time),  32'(hms(0, 59, 0)));
    pulse(0, 1, 1);
    check("inc_dec",     32'(bus.load_time),  32'(hms(0, 59, 0)));
    check("still_min",   32'(bus.field_sel),  32'd2);

    // 4: asynchronous reset in the middle of SET_M
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("after_rst_load", 32'(bus.load),       32'd0);
      check("after_rst_set",  32'(bus.set_active), 32'd0);
    end
    bus.cur_time = hms(31, 10, 5);
    pulse(1, 0, 0);
    check("oor_capture", 32'(bus.load_time), 32'(hms(0, 10, 5)));
    check("oor_field",   32'(bus.field_sel), 32'd1);
    check("blink_s1",    32'(bus.blink),     32'd0);

    // 6: mode wins over inc; blink cadence across SET states
    pulse(1, 1, 0);
    check("mode_wins_field", 32'(bus.field_sel), 32'd2);
    check("mode_wins_time",  32'(bus.load_time), 32'(hms(0, 10, 5)));
    check("blink_s2",        32'(bus.blink),     32'd0);
    step(); check("blink_s3", 32'(bus.blink), 32'd1);
    step(); check("blink_s4", 32'(bus.blink), 32'd1);
    step(); check("blink_s5", 32'(bus.blink), 32'd0);
    step(); check("blink_s6", 32'(bus.blink), 32'd0);
    step(); check("blink_s7", 32'(bus.blink), 32'd1);

    // 5: idle in SET_S
    pulse(1, 0, 0);
    check("enter_sec", 32'(bus.field_sel), 32'd3);
`ifdef CLOCK_SET_TIMEOUT_EN
    for (int t = 1; t <= 15; t++) begin
      step();
      check("idle_set",  32'(bus.set_active), 32'd1);
      check("idle_load", 32'(bus.load),       32'd0);
    end
    step();
    check("timeout_set",   32'(bus.set_active), 32'd0);
    check("timeout_field", 32'(bus.field_sel),  32'd0);
    check("timeout_load",  32'(bus.load),       32'd0);
    for (int t = 17; t <= 23; t++) begin
      step();
      check("timeout_tick", 32'(bus.tick_1hz), 32'(t == 23));
      check("timeout_noload", 32'(bus.load),   32'd0);
    end
`else
    for (int t = 1; t <= 100; t++) begin
      step();
      check("persist_load", 32'(bus.load), 32'd0);
    end
    check("persist_set",   32'(bus.set_active), 32'd1);
    check("persist_field", 32'(bus.field_sel),  32'd3);
    pulse(1, 0, 0);
    check("late_commit",      32'(bus.load),      32'd1);
    check("late_commit_time", 32'(bus.load_time), 32'(hms(0, 10, 5)));
    step();
    check("late_commit_end",  32'(bus.load),      32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
